fp_cc_tracker: RTL and testbench
================================

Name: fp_cc_tracker

Overview:
- Consumer end of the FP compare pipeline.
- Launches compares alongside the D-stage fp_compare, tracks the in-flight destination condition-code index, and writes the 1-bit compare result into an 8-entry FP condition-code register (MIPS cc0..cc7) when it emerges D cycles later.
- Serves FCC reads for bc1t/bc1f/movt/movf with a req/ack handshake. Reads stall while a write to the same cc is in flight.

Parameters:
- D, 4: compare pipeline latency in cycles; must equal the fp_compare D it is paired with; legal range 1..15.
- NCC, 8: number of condition-code bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmp_start  in  1  compare issued this cycle; same cycle as the fp_compare start
- cmp_cc  in  3  destination cc index of the issuing compare
- cmp_y  in  1  fp_compare output; meaningful only in the cycle a tracked compare completes
- flush  in  1  kill all in-flight compares (pipeline squash)
- rd_req  in  1  FCC read request; held high with rd_cc stable until rd_ack
- rd_cc  in  3  cc index to read
- rd_ack  out  1  registered; one-cycle pulse, read data valid
- rd_val  out  1  registered; fcc[rd_cc] value returned with rd_ack
- fcc  out  NCC  architectural condition-code register
- busy  out  1  any compare in flight

Behaviour:
- Reset: fcc=0, rd_ack=0, rd_val=0, busy=0, all tracking state cleared. Reset asserted mid-operation discards in-flight compares; no write occurs after reset.
- Tracking pipe: D-stage shift of {valid, cc}.
  - Stage 0 loads {cmp_start & ~flush, cmp_cc}.
  - Stage D-1 is the completing stage.
  - When the completing stage is valid: fcc[cc] <= cmp_y at the clock edge.
- Pending counters: one per cc, width ceil(log2(D+1)).
  - Increment on accepted start to that cc.
  - Decrement on completion from that cc.
  - Same-cc start and completion in one cycle: net unchanged.
- Multiple in-flight compares to the same cc: retire in issue order; the last one's result persists.
- flush:
  - Clears all valid bits and pending counters that cycle; no write occurs from the completing stage in that cycle.
  - A cmp_start in the same cycle is dropped (flush wins).
- Read hazard:
  - A read is serviceable when pend[rd_cc]==0.
  - If serviceable in cycle N: rd_ack=1 and rd_val=fcc[rd_cc] in cycle N+1, where fcc is the value after any cycle-N write to a different cc.
  - Otherwise no ack; re-evaluated each cycle.
- rd_req still high in the ack cycle is treated as a new request (back-to-back reads: one ack per cycle).
- busy = OR of the valid bits.
- Pending counter never exceeds D; overflow is impossible by construction. An assertion fires on underflow.

Optional Feature:
- FP_CC_BYPASS_EN defined: a read is also serviceable when pend[rd_cc]==1 and the completing stage is valid with cc==rd_cc. rd_val is then cmp_y from that cycle, ack next cycle. This saves one cycle on the compare-to-branch path.
- Undefined: such a read waits until the write lands in fcc; ack arrives one cycle later than with bypass.

Test Plan:
- Reset then idle; read cc3 -> rd_ack 1 cycle later, rd_val=0, fcc=8'h00, busy=0.
- D=4: start cc2 at cycle 0; cmp_y=1 at cycle 4 -> fcc=8'h04 after cycle 4 edge. rd_req cc2 held from cycle 1:
  - no bypass: rd_ack at cycle 6, rd_val=1;
  - with FP_CC_BYPASS_EN: rd_ack at cycle 5, rd_val=1.
- Starts to cc1 at cycles 0 and 1 with cmp_y=1 then 0 -> fcc[1]=0 at the end; read of cc1 not acked before both complete; read of cc0 during flight acked next cycle with value 0.
- Start cc5 at cycle 0; flush at cycle 2 with cmp_y=1 at cycle 4 -> fcc[5] stays 0, busy=0 from cycle 3, pending read of cc5 acked at cycle 4 with rd_val=0.
- Flush and cmp_start (cc6) in the same cycle -> no write to cc6, busy=0.
- Reset asserted while three compares are in flight -> no fcc writes afterwards, fcc=0, counters zero.

Source files
------------

// File: rtl/fp_cc_tracker.sv
// FP condition-code tracker: follows in-flight compares, writes results
// into the cc register and serves hazard-checked FCC reads. Optional: FP_CC_BYPASS_EN.
module fp_cc_tracker #(
    parameter int D   = 4,
    parameter int NCC = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmp_start,
    input  logic [2:0]     cmp_cc,
    input  logic           cmp_y,
    input  logic           flush,
    input  logic           rd_req,
    input  logic [2:0]     rd_cc,
    output logic           rd_ack,
    output logic           rd_val,
    output logic [NCC-1:0] fcc,
    output logic           busy
);

    localparam int PW = $clog2(D + 1);

    logic [D-1:0]    vld;
    logic [2:0]      pcc [D];
    logic [PW-1:0]   pend [NCC];
    logic            start_ok;
    logic            done;
    logic [2:0]      done_cc;
    logic [NCC-1:0]  fcc_nx;
    logic            svc;

    assign start_ok = cmp_start & ~flush;
    assign done     = vld[D-1] & ~flush;
    assign done_cc  = pcc[D-1];
    assign busy     = |vld;

    // Next cc register value including this cycle's completing write
    always_comb begin
        fcc_nx = fcc;
        if (done)
            fcc_nx[done_cc] = cmp_y;
    end

    // Read is serviceable when no write to that cc is still in flight
    always_comb begin
        svc = (pend[rd_cc] == '0);
`ifdef FP_CC_BYPASS_EN
        if (pend[rd_cc] == PW'(1) && done && done_cc == rd_cc)
            svc = 1'b1;
`else
`endif
    end

    // Tracking pipe of {valid, cc}; last stage is the completing stage
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld <= '0;
            for (int i = 0; i < D; i++)
                pcc[i] <= '0;
        end else begin
            vld[0] <= start_ok;
            pcc[0] <= cmp_cc;
            for (int i = 1; i < D; i++) begin
                vld[i] <= vld[i-1];
                pcc[i] <= pcc[i-1];
            end
        end
    end

    // Per-cc pending counters: +1 on accepted start, -1 on completion
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCC; c++) begin
            if (reset || flush) begin
                pend[c] <= '0;
            end else begin
                if (start_ok && cmp_cc == 3'(c) && !(done && done_cc == 3'(c)))
                    pend[c] <= pend[c] + PW'(1);
                else if (done && done_cc == 3'(c) && !(start_ok && cmp_cc == 3'(c)))
                    pend[c] <= pend[c] - PW'(1);
            end
        end
    end

    // A completion must always have a matching pending count
    always_ff @(posedge clk) begin
        if (!reset && done)
            assert (pend[done_cc] != '0);
    end

    // Architectural cc register update
    always_ff @(posedge clk) begin
        if (reset)
            fcc <= '0;
        else
            fcc <= fcc_nx;
    end

    // Registered read response, one ack per serviceable request cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ack <= 1'b0;
            rd_val <= 1'b0;
        end else begin
            rd_ack <= rd_req & svc;
            rd_val <= (rd_req & svc) ? fcc_nx[rd_cc] : 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_cc_tracker.sv
// Directed self-checking bench for fp_cc_tracker (D=4, NCC=8).
// Ack cycles depend on whether FP_CC_BYPASS_EN is defined.
module tb_fp_cc_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmp_start;
    logic [2:0] cmp_cc;
    logic       cmp_y;
    logic       flush;
    logic       rd_req;
    logic [2:0] rd_cc;
    logic       rd_ack;
    logic       rd_val;
    logic [7:0] fcc;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int ack2;
    int ack3;

    fp_cc_tracker #(.D(4), .NCC(8)) dut (
        .clk(clk), .reset(reset), .cmp_start(cmp_start), .cmp_cc(cmp_cc),
        .cmp_y(cmp_y), .flush(flush), .rd_req(rd_req), .rd_cc(rd_cc),
        .rd_ack(rd_ack), .rd_val(rd_val), .fcc(fcc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef FP_CC_BYPASS_EN
        ack2 = 5;
        ack3 = 6;
`else
        ack2 = 6;
        ack3 = 7;
`endif
        reset = 1'b1; cmp_start = 1'b0; cmp_cc = 3'd0; cmp_y = 1'b0;
        flush = 1'b0; rd_req = 1'b0; rd_cc = 3'd0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state and idle read of cc3
        chk("rst_fcc", 32'(fcc), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(rd_ack), 32'd0);
        chk("rst_val", 32'(rd_val), 32'd0);
        rd_req = 1'b1; rd_cc = 3'd3;
        tick();
        chk("idle_ack", 32'(rd_ack), 32'd1);
        chk("idle_val", 32'(rd_val), 32'd0);
        rd_req = 1'b0;
        tick();
        chk("idle_ack_drop", 32'(rd_ack), 32'd0);

        // Single compare to cc2, result 1, read held from cycle 1
        cmp_start = 1'b1; cmp_cc = 3'd2;
        tick();
        chk("t2_busy", 32'(busy), 32'd1);
        cmp_start = 1'b0; rd_req = 1'b1; rd_cc = 3'd2;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("t2_ack_c%0d", c), 32'(rd_ack), 32'(c == ack2));
            if (c == ack2) begin
                chk("t2_val", 32'(rd_val), 32'd1);
                rd_req = 1'b0;
            end
            if (c == 5)
                chk("t2_fcc", 32'(fcc), 32'h04);
            cmp_y = (c == 4);
            tick();
        end
        chk("t2_busy_end", 32'(busy), 32'd0);

        // Two compares to cc1 (1 then 0); read cc0 in flight, then cc1
        cmp_start = 1'b1; cmp_cc = 3'd1;
        tick();
        rd_req = 1'b1; rd_cc = 3'd0;
        tick();
        chk("t3_cc0_ack", 32'(rd_ack), 32'd1);
        chk("t3_cc0_val", 32'(rd_val), 32'd0);
        cmp_start = 1'b0; rd_cc = 3'd1;
        for (int c = 2; c <= 9; c++) begin
            if (c > 2)
                chk($sformatf("t3_ack_c%0d", c), 32'(rd_ack), 32'(c == ack3));
            if (c == ack3) begin
                chk("t3_val", 32'(rd_val), 32'd0);
                rd_req = 1'b0;
            end
            if (c == 5)
                chk("t3_fcc_mid", 32'(fcc), 32'h06);
            if (c == 6)
                chk("t3_fcc_end", 32'(fcc), 32'h04);
            cmp_y = (c == 4);
            tick();
        end

        // Flush kills an in-flight compare to cc5
        cmp_start = 1'b1; cmp_cc = 3'd5;
        tick();
        cmp_start = 1'b0; rd_req = 1'b1; rd_cc = 3'd5;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_ack_c3", 32'(rd_ack), 32'd0);
        tick();
        chk("t4_ack_c4", 32'(rd_ack), 32'd1);
        chk("t4_val", 32'(rd_val), 32'd0);
        rd_req = 1'b0; cmp_y = 1'b1;
        tick();
        cmp_y = 1'b0;
        chk("t4_fcc", 32'(fcc), 32'h04);

        // Flush and start to cc6 in the same cycle
        cmp_start = 1'b1; cmp_cc = 3'd6; flush = 1'b1;
        tick();
        cmp_start = 1'b0; flush = 1'b0; cmp_y = 1'b1;
        chk("t5_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 5; c++)
            tick();
        cmp_y = 1'b0;
        chk("t5_fcc", 32'(fcc), 32'h04);

        // Reset with three compares in flight
        cmp_start = 1'b1; cmp_cc = 3'd0;
        tick();
        cmp_cc = 3'd1;
        tick();
        cmp_cc = 3'd7;
        tick();
        cmp_start = 1'b0;
        chk("t6_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0; cmp_y = 1'b1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_fcc_rst", 32'(fcc), 32'h00);
        rd_req = 1'b1; rd_cc = 3'd7;
        tick();
        chk("t6_rd_ack", 32'(rd_ack), 32'd1);
        chk("t6_rd_val", 32'(rd_val), 32'd0);
        rd_req = 1'b0;
        for (int c = 0; c < 5; c++)
            tick();
        cmp_y = 1'b0;
        chk("t6_fcc_end", 32'(fcc), 32'h00);
        chk("t6_busy_end", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
